// File: rtl/can_bus_pkg.sv
// Shared CAN bus constants and the run-counter width helper.
package can_bus_pkg;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    // Bits needed to hold a dominant run count of 0..timeout.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/can_bit_dly.sv
// DEPTH-stage single-bit delay line; reset fills every stage with recessive.
module can_bit_dly
    import can_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            // Single register stage.
            always_ff @(posedge clock) begin
                if (reset) sr <= CAN_RECESSIVE;
                else       sr <= d;
            end
        end else begin : g_multi
            // Shift towards the MSB; the MSB is the oldest bit.
            always_ff @(posedge clock) begin
                if (reset) sr <= {DEPTH{CAN_RECESSIVE}};
                else       sr <= {sr[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/can_bus_model.sv
// N-node wired-AND CAN bus with TX/RX propagation delays, per-node detach,
// start-of-frame and stuck-dominant monitors.
// Optional: define CAN_BUS_FAULT_INJ_EN to add fi_flip, a per-node RX glitch input.
module can_bus_model
    import can_bus_pkg::*;
#(
    parameter int unsigned NUM_NODES   = 2,
    parameter int unsigned TX_DLY      = 2,
    parameter int unsigned RX_DLY      = 1,
    parameter int unsigned DOM_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = cnt_width(DOM_TIMEOUT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_NODES-1:0] can_tx,
    input  logic [NUM_NODES-1:0] node_en,
`ifdef CAN_BUS_FAULT_INJ_EN
    input  logic [NUM_NODES-1:0] fi_flip,
`endif
    output logic [NUM_NODES-1:0] can_rx,
    output logic                 bus_level,
    output logic                 sof_pulse,
    output logic [CNT_W-1:0]     dom_run_cnt,
    output logic                 dom_stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(DOM_TIMEOUT);

    logic [NUM_NODES-1:0] tx_out;
    logic [NUM_NODES-1:0] rx_in;
    logic [NUM_NODES-1:0] rx_out;
    logic                 bus_next;
    logic [CNT_W-1:0]     cnt_next;

    // Per-node TX and RX delay lines.
    generate
        for (genvar i = 0; i < int'(NUM_NODES); i++) begin : g_node
`ifdef CAN_BUS_FAULT_INJ_EN
            assign rx_in[i] = bus_level ^ fi_flip[i];
`else
            assign rx_in[i] = bus_level;
`endif
            can_bit_dly #(.DEPTH(TX_DLY)) u_tx_dly (
                .clock (clock),
                .reset (reset),
                .d     (can_tx[i]),
                .q     (tx_out[i])
            );

            can_bit_dly #(.DEPTH(RX_DLY)) u_rx_dly (
                .clock (clock),
                .reset (reset),
                .d     (rx_in[i]),
                .q     (rx_out[i])
            );
        end
    endgenerate

    // Wired-AND of attached transmitters; detached nodes read as recessive.
    assign bus_next = &(tx_out | ~node_en);

    // Detached nodes see a recessive bus regardless of what is in their RX line.
    assign can_rx = rx_out | ~node_en;

    // Saturating dominant run length as it will be after this edge.
    always_comb begin
        cnt_next = dom_run_cnt;
        if (bus_next == CAN_RECESSIVE)   cnt_next = '0;
        else if (dom_run_cnt != TIMEOUT_V) cnt_next = dom_run_cnt + CNT_W'(1);
    end

    // Resolved bus register and monitors; bus_level doubles as the previous level for SOF.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_level   <= CAN_RECESSIVE;
            sof_pulse   <= 1'b0;
            dom_run_cnt <= '0;
            dom_stuck   <= 1'b0;
        end else begin
            bus_level   <= bus_next;
            sof_pulse   <= (bus_level == CAN_RECESSIVE) && (bus_next == CAN_DOMINANT);
            dom_run_cnt <= cnt_next;
            dom_stuck   <= dom_stuck || (cnt_next == TIMEOUT_V);
        end
    end

endmodule

// File: tb/tb_can_bus_model.sv
// Randomized scoreboard bench for can_bus_model (4 nodes, DOM_TIMEOUT = 8).
module tb_can_bus_model;

    localparam int NN   = 4;
    localparam int TXD  = 2;
    localparam int RXD  = 1;
    localparam int TO   = 8;
    localparam int CW   = $clog2(TO + 1);
    localparam int MAXC = 1024;
    localparam logic [NN-1:0] ALL1 = '1;

    logic          clock = 1'b0;
    logic          reset;
    logic [NN-1:0] can_tx;
    logic [NN-1:0] node_en;
    logic [NN-1:0] can_rx;
    logic          bus_level;
    logic          sof_pulse;
    logic [CW-1:0] dom_run_cnt;
    logic          dom_stuck;
`ifdef CAN_BUS_FAULT_INJ_EN
    logic [NN-1:0] fi_flip;
`endif

    can_bus_model #(
        .NUM_NODES   (NN),
        .TX_DLY      (TXD),
        .RX_DLY      (RXD),
        .DOM_TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .can_tx      (can_tx),
        .node_en     (node_en),
`ifdef CAN_BUS_FAULT_INJ_EN
        .fi_flip     (fi_flip),
`endif
        .can_rx      (can_rx),
        .bus_level   (bus_level),
        .sof_pulse   (sof_pulse),
        .dom_run_cnt (dom_run_cnt),
        .dom_stuck   (dom_stuck)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          bus;
        logic          sof;
        logic [CW-1:0] cnt;
        logic          stuck;
        logic [NN-1:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Inputs as sampled at edge n, and model state after edge n.
    logic [NN-1:0] txs[MAXC];
    logic [NN-1:0] ens[MAXC];
    logic [NN-1:0] fls[MAXC];
    logic          rst_h[MAXC];
    logic          bus_m[MAXC];
    int            cnt_m[MAXC];
    logic          stuck_m[MAXC];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // True if any reset was sampled at edges a..b, or a predates the start of time.
    function automatic logic rst_in(input int a, input int b);
        logic hit;
        hit = (a < 1);
        for (int j = (a < 1 ? 1 : a); j <= b; j++)
            if (rst_h[j]) hit = 1'b1;
        return hit;
    endfunction

    // Expected outputs after edge n; can_rx uses node_en sampled at edge n+1 (current value).
    function automatic exp_t model(input int n);
        exp_t e;
        logic b;
        int   c;
        logic s;
        logic r;
        b = rst_in(n - TXD, n) ? 1'b1 : &(txs[n - TXD] | ~ens[n]);
        if (rst_h[n]) begin
            e.sof = 1'b0;
            c     = 0;
            s     = 1'b0;
        end else begin
            e.sof = bus_m[n-1] & ~b;
            c     = b ? 0 : ((cnt_m[n-1] >= TO) ? TO : cnt_m[n-1] + 1);
            s     = stuck_m[n-1] | (c == TO);
        end
        bus_m[n]   = b;
        cnt_m[n]   = c;
        stuck_m[n] = s;
        e.bus   = b;
        e.cnt   = CW'(c);
        e.stuck = s;
        for (int i = 0; i < NN; i++) begin
            r = rst_in(n - RXD + 1, n) ? 1'b1 : (bus_m[n - RXD] ^ fls[n - RXD + 1][i]);
            e.rx[i] = r | ~ens[n+1][i];
        end
        return e;
    endfunction

    // Apply inputs for the next edge, score the state after the previous edge, then advance.
    task automatic drive(input logic [NN-1:0] tx, input logic [NN-1:0] en,
                         input logic r, input logic [NN-1:0] fl);
        logic [NN-1:0] fl_eff;
        int k;
`ifdef CAN_BUS_FAULT_INJ_EN
        fl_eff  = fl;
        fi_flip = fl;
`else
        fl_eff  = fl & '0;
`endif
        can_tx  = tx;
        node_en = en;
        reset   = r;
        k = cyc + 1;
        if (k < MAXC - 1) begin
            txs[k] = tx; ens[k] = en; rst_h[k] = r; fls[k] = fl_eff;
            if (cyc > 0) exp_q.push_back(model(cyc));
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(ALL1, ALL1, 1'b0, '0);
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bus_level",   int'(bus_level),   int'(e.bus));
            chk("sof_pulse",   int'(sof_pulse),   int'(e.sof));
            chk("dom_run_cnt", int'(dom_run_cnt), int'(e.cnt));
            chk("dom_stuck",   int'(dom_stuck),   int'(e.stuck));
            chk("can_rx",      int'(can_rx),      int'(e.rx));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NN-1:0] tx;
        logic [NN-1:0] en;
        int hold;
        bus_m[0] = 1'b1; cnt_m[0] = 0; stuck_m[0] = 1'b0;
        rst_h[0] = 1'b1; txs[0] = ALL1; ens[0] = ALL1; fls[0] = '0;

        // Reset and idle recessive bus.
        repeat (3) drive(ALL1, ALL1, 1'b1, '0);
        idle(5);

        // Single dominant bit from node 0.
        drive(4'b1110, ALL1, 1'b0, '0);
        idle(8);

        // Node 2 dominant against recessive nodes 1 and 3, then node 2 detached.
        repeat (6) drive(4'b1011, ALL1, 1'b0, '0);
        repeat (4) drive(4'b1011, 4'b1011, 1'b0, '0);
        idle(6);

        // Long dominant run: saturation and sticky flag, then release.
        repeat (20) drive(4'b1110, ALL1, 1'b0, '0);
        idle(6);

        // Reset pulse in the middle of a dominant run.
        repeat (5) drive(4'b1110, ALL1, 1'b0, '0);
        drive(4'b1110, ALL1, 1'b1, '0);
        repeat (6) drive(4'b1110, ALL1, 1'b0, '0);
        idle(5);

        // RX glitch on node 1 with an idle bus.
        drive(ALL1, ALL1, 1'b0, 4'b0010);
        idle(4);

        // Random traffic with occasional detach, reset and glitches.
        tx = ALL1; en = ALL1; hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                for (int i = 0; i < NN; i++) tx[i] = ($urandom_range(3) != 0);
                hold = $urandom_range(12, 1);
            end
            hold--;
            if ($urandom_range(15) == 0) en = NN'($urandom);
            drive(tx, en, ($urandom_range(63) == 0), NN'($urandom) & NN'($urandom) & NN'($urandom));
        end
        idle(2);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_bus_model.md
# can_bus_model

Clocked, parametrised N-node CAN bus model for simulation and FPGA loopback benches. It resolves any number of node TX lines onto one wired-AND bus (dominant = 0), applies configurable TX and RX propagation delays, and supports per-node disconnect. It also monitors the bus for stuck-dominant faults and start-of-frame edges. It sits between CAN controller instances and replaces the two-node combinational PHY/bus model.

## Interface
- NUM_NODES, 2: attached nodes, ≥2.
- TX_DLY, 2: cycles from node TX to bus resolution stage, ≥1.
- RX_DLY, 1: cycles from resolved bus to node RX, ≥1.
- DOM_TIMEOUT, 1024: consecutive dominant cycles that flag a stuck bus, ≥2.
- CNT_W, $clog2(DOM_TIMEOUT+1): derived width of the run counter; not overridden.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- can_tx  in  NUM_NODES  per-node TX bit; 0 = dominant.
- node_en  in  NUM_NODES  1 = node attached; 0 = node's TX ignored and its RX reads recessive.
- can_rx  out  NUM_NODES  per-node delayed bus view.
- bus_level  out  1  registered resolved bus.
- sof_pulse  out  1  one-cycle pulse on a recessive→dominant bus transition.
- dom_run_cnt  out  CNT_W  current dominant run length, saturating.
- dom_stuck  out  1  sticky stuck-dominant flag.
- fi_flip  in  NUM_NODES  present only with CAN_BUS_FAULT_INJ_EN; see Configuration.

## Operation
- Per node i, the TX delay line is a TX_DLY-stage shift register fed by can_tx[i].
- Resolution: bus_level <= AND over i of (tx_out[i] | ~node_en[i]). If no node is enabled, the bus is recessive.
- Per node i, the RX delay line is an RX_DLY-stage shift register fed by bus_level.
- can_rx[i] = rx_out[i] | ~node_en[i]. This is the only combinational path and is gated by node_en.
- sof_pulse <= bus_prev & ~bus_level_next. It is registered and aligned with bus_level going 0.
- Dominant run counter: increments each cycle bus_level = 0, saturates at DOM_TIMEOUT, and clears to 0 in any cycle bus_level = 1.
- dom_stuck sets when dom_run_cnt reaches DOM_TIMEOUT. It stays set until reset, even after the bus returns recessive.
- node_en changes take effect at the resolution stage on the next edge. Bits already in delay lines are not flushed.

## Timing
- Reset values:
  - all delay-line stages 1
  - bus_level 1
  - bus_prev 1
  - sof_pulse 0
  - dom_run_cnt 0
  - dom_stuck 0
  - can_rx all 1
- Latency from can_tx to bus_level is TX_DLY+1 edges.
- Latency from can_tx to can_rx is TX_DLY+1+RX_DLY edges; with defaults this is 4.
- Simultaneous dominant and recessive transmitters: dominant wins. Each node sees the same resolved value after RX_DLY.
- Reset asserted mid-frame: every stage returns recessive on that edge and sof_pulse stays 0. The first dominant after reset release produces sof_pulse.
- At saturation dom_run_cnt holds at DOM_TIMEOUT without wrapping.

## Configuration
- CAN_BUS_FAULT_INJ_EN defined:
  - fi_flip port exists.
  - When fi_flip[i] = 1 at an edge, the value shifted into node i's RX stage 0 is inverted, giving a one-bit glitch seen RX_DLY cycles later by node i only.
  - Bus resolution and monitors are unaffected.
- CAN_BUS_FAULT_INJ_EN undefined: no fi_flip port and no inversion logic.

## Structure
- Package can_bus_pkg holds CAN_DOMINANT = 1'b0 and CAN_RECESSIVE = 1'b1. It also holds the function computing CNT_W.
- Sub-module can_bit_dly: parametrised DEPTH shift register with synchronous reset to CAN_RECESSIVE. It is instantiated twice per node, once for TX and once for RX.
- Top instantiates the delay lines via generate, the AND-reduction, and the monitors.

## Test plan
- Reset, all can_tx = 1 → can_rx all 1, bus_level 1, dom_run_cnt 0, dom_stuck 0, sof_pulse never asserted.
- Defaults, node 0 drives 0 for one cycle at edge k → bus_level 0 at edge k+3, sof_pulse high that cycle, can_rx[0] and can_rx[1] both 0 at edge k+4 for exactly one cycle.
- NUM_NODES = 4, nodes 1 and 3 send 1 while node 2 sends 0 → all can_rx show 0. Then set node_en[2] = 0 → bus recessive, can_rx[2] = 1 immediately.
- DOM_TIMEOUT = 8, hold node 0 dominant for 20 cycles, then release → dom_stuck rises when dom_run_cnt = 8. dom_run_cnt holds at 8, then clears to 0 after release while dom_stuck stays 1.
- Reset pulse during a dominant run → next edge: bus_level 1, dom_run_cnt 0, dom_stuck 0, no sof_pulse.
- With CAN_BUS_FAULT_INJ_EN defined, bus recessive, pulse fi_flip[1] one cycle → can_rx[1] = 0 for one cycle RX_DLY later, can_rx[0] stays 1, bus_level stays 1.
